// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared width and saturation helpers for pipelined_mult_stream
package mult_pkg;

  localparam int LIMIT_WIDTH = 128;
  typedef logic signed [LIMIT_WIDTH-1:0] limit_t;

  function automatic int seg_width(input int b_width, input int segments);
    return b_width / segments;
  endfunction

  function automatic int prod_width(input int a_width, input int b_width);
    return a_width + b_width;
  endfunction

  function automatic limit_t sat_hi(input int width);
    limit_t one;
    one = LIMIT_WIDTH'(1);
    return (one <<< (width - 1)) - one;
  endfunction

  function automatic limit_t sat_lo(input int width);
    limit_t one;
    one = LIMIT_WIDTH'(1);
    return -(one <<< (width - 1));
  endfunction

  // Half-LSB bias so the later arithmetic shift rounds half toward +inf.
  function automatic limit_t round_bias(input int shift);
    limit_t one;
    one = LIMIT_WIDTH'(1);
    if (shift <= 0) return '0;
    return one <<< (shift - 1);
  endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// rtl/mult_pipe_stage.sv - valid/hold register slice used for every multiplier stage
module mult_pipe_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  up_valid,
  input  logic [DATA_WIDTH-1:0] up_data,
  input  logic                  down_advance,
  output logic                  advance,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);

  // An empty stage is always free, so bubbles never stall upstream.
  assign advance = !valid || down_advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (advance) begin
      valid <= up_valid;
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/pipelined_mult_stream.sv
// rtl/pipelined_mult_stream.sv - 3-stage segmented multiplier with backpressure, tag passthrough and round/saturate
module pipelined_mult_stream
  import mult_pkg::*;
#(
  parameter int A_WIDTH    = 18,
  parameter int B_WIDTH    = 18,
  parameter int SEGMENTS   = 2,
  parameter int B_SIGNED   = 1,
  parameter int OUT_SHIFT  = 0,
  parameter int OUT_WIDTH  = 36,
  parameter int USER_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [A_WIDTH-1:0]    i_A,
  input  logic [B_WIDTH-1:0]    i_B,
  input  logic [USER_WIDTH-1:0] i_user,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [OUT_WIDTH-1:0]  o_out,
  output logic [USER_WIDTH-1:0] o_user,
  output logic                  o_sat
);

  localparam int S   = seg_width(B_WIDTH, SEGMENTS);
  localparam int P   = prod_width(A_WIDTH, B_WIDTH);
  localparam int PX  = P + 1;
  localparam int PPW = A_WIDTH + S + 1;
  localparam int CW  = (PX > OUT_WIDTH) ? PX : OUT_WIDTH;
  localparam int D1W = SEGMENTS * PPW + USER_WIDTH;
  localparam int D2W = P + USER_WIDTH;
  localparam int D3W = OUT_WIDTH + 1 + USER_WIDTH;

  localparam limit_t HI_FULL   = sat_hi(OUT_WIDTH);
  localparam limit_t LO_FULL   = sat_lo(OUT_WIDTH);
  localparam limit_t BIAS_FULL = round_bias(OUT_SHIFT);
  localparam logic signed [CW-1:0]        SAT_HI = HI_FULL[CW-1:0];
  localparam logic signed [CW-1:0]        SAT_LO = LO_FULL[CW-1:0];
  localparam logic signed [OUT_WIDTH-1:0] OUT_HI = HI_FULL[OUT_WIDTH-1:0];
  localparam logic signed [OUT_WIDTH-1:0] OUT_LO = LO_FULL[OUT_WIDTH-1:0];
  localparam logic signed [P:0]           RND    = BIAS_FULL[P:0];

  if (B_WIDTH % SEGMENTS != 0 || OUT_SHIFT >= P) begin : g_bad_cfg
    $error("pipelined_mult_stream: B_WIDTH must divide by SEGMENTS and OUT_SHIFT must be below A_WIDTH+B_WIDTH");
  end

  logic           adv1, adv2, adv3;
  logic           v1, v2, v3;
  logic [D1W-1:0] s1_data;
  logic [D2W-1:0] s2_data;
  logic [D3W-1:0] s3_data;

  // Stage 1: one partial product per B slice; only the top slice may carry sign.
  logic [SEGMENTS*PPW-1:0] pp_flat;
  for (genvar k = 0; k < SEGMENTS; k++) begin : g_pp
    logic signed [S:0] slice;
    if (k == SEGMENTS - 1 && B_SIGNED != 0) begin : g_signed
      assign slice = {i_B[k*S+S-1], i_B[k*S +: S]};
    end else begin : g_unsigned
      assign slice = {1'b0, i_B[k*S +: S]};
    end
    assign pp_flat[k*PPW +: PPW] = PPW'($signed(i_A)) * PPW'(slice);
  end

  mult_pipe_stage #(.DATA_WIDTH(D1W)) u_stage1 (
    .clk(i_clk), .rst_n(i_reset_n), .up_valid(i_valid), .up_data({i_user, pp_flat}),
    .down_advance(adv2), .advance(adv1), .valid(v1), .data(s1_data)
  );

  // Stage 2: the weighted sum is exact modulo 2^P because the true product fits in P bits.
  logic signed [P-1:0] sum;
  always_comb begin
    sum = '0;
    for (int k = 0; k < SEGMENTS; k++)
      sum = sum + (P'($signed(s1_data[k*PPW +: PPW])) <<< (k * S));
  end

  mult_pipe_stage #(.DATA_WIDTH(D2W)) u_stage2 (
    .clk(i_clk), .rst_n(i_reset_n), .up_valid(v1), .up_data({s1_data[D1W-1 -: USER_WIDTH], sum}),
    .down_advance(adv3), .advance(adv2), .valid(v2), .data(s2_data)
  );

  logic signed [P-1:0]         s2_sum;
  logic signed [P:0]           rounded;
  logic signed [CW-1:0]        rnd_wide;
  logic signed [OUT_WIDTH-1:0] res;
  logic                        sat;

  assign s2_sum   = s2_data[P-1:0];
  assign rounded  = (PX'(s2_sum) + RND) >>> OUT_SHIFT;
  assign rnd_wide = CW'(rounded);

  always_comb begin
    sat = 1'b1;
    res = OUT_HI;
    if (rnd_wide > SAT_HI) begin
      res = OUT_HI;
    end else if (rnd_wide < SAT_LO) begin
      res = OUT_LO;
    end else begin
      sat = 1'b0;
      res = rnd_wide[OUT_WIDTH-1:0];
    end
  end

  mult_pipe_stage #(.DATA_WIDTH(D3W)) u_stage3 (
    .clk(i_clk), .rst_n(i_reset_n), .up_valid(v2), .up_data({s2_data[D2W-1 -: USER_WIDTH], sat, res}),
    .down_advance(i_ready), .advance(adv3), .valid(v3), .data(s3_data)
  );

  assign o_ready = adv1;
  assign o_valid = v3;
  assign o_out   = s3_data[OUT_WIDTH-1:0];
  assign o_sat   = s3_data[OUT_WIDTH];
  assign o_user  = s3_data[D3W-1 -: USER_WIDTH];

endmodule

// File: tb/tb_pipelined_mult_stream.sv
// tb/tb_pipelined_mult_stream.sv - self-checking bench for pipelined_mult_stream (three configurations)
module tb_pipelined_mult_stream;

  typedef struct {
    longint     e0;
    longint     e1;
    longint     e2;
    logic       s2;
    logic [7:0] user;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [17:0] a_in = '0;
  logic [17:0] b_in = '0;
  logic [7:0]  user_in = '0;

  logic        rdy0, rdy1, rdy2, v0, v1, v2, sat0, sat1, sat2;
  logic [35:0] out0, out1;
  logic [15:0] out2;
  logic [7:0]  u0, u1, u2;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   n_res = 0;
  int   n_acc = 0;
  bit   lat_mode = 0;
  bit   stalled_prev = 0;
  bit   acc_flag = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  pipelined_mult_stream u_def (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(in_valid), .o_ready(rdy0), .i_A(a_in), .i_B(b_in),
    .i_user(user_in), .o_valid(v0), .i_ready(out_ready), .o_out(out0), .o_user(u0), .o_sat(sat0)
  );

  pipelined_mult_stream #(.SEGMENTS(3), .B_SIGNED(0)) u_seg (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(in_valid), .o_ready(rdy1), .i_A(a_in), .i_B(b_in),
    .i_user(user_in), .o_valid(v1), .i_ready(out_ready), .o_out(out1), .o_user(u1), .o_sat(sat1)
  );

  pipelined_mult_stream #(.OUT_SHIFT(4), .OUT_WIDTH(16)) u_rnd (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(in_valid), .o_ready(rdy2), .i_A(a_in), .i_B(b_in),
    .i_user(user_in), .o_valid(v2), .i_ready(out_ready), .o_out(out2), .o_user(u2), .o_sat(sat2)
  );

  function automatic logic [63:0] sx36(input logic [35:0] v);
    return {{28{v[35]}}, v};
  endfunction

  function automatic logic [63:0] sx16(input logic [15:0] v);
    return {{48{v[15]}}, v};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact products from plain integer arithmetic, then round-half-up and clamp.
  task automatic push_model();
    exp_t   e;
    longint a, bs, bu, r;
    a  = longint'($signed(a_in));
    bs = longint'($signed(b_in));
    bu = longint'(b_in);
    e.e0 = a * bs;
    e.e1 = a * bu;
    r = (e.e0 + 64'sd8) >>> 4;
    e.s2 = (r > 32767) || (r < -32768);
    e.e2 = (r > 32767) ? 64'sd32767 : ((r < -32768) ? -64'sd32768 : r);
    e.user = user_in;
    e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic rand_in();
    a_in    = 18'($urandom);
    b_in    = 18'($urandom);
    user_in = 8'($urandom);
  endtask

  task automatic step();
    exp_t e;
    logic exp_rdy;
    @(negedge clk);
    cyc++;
    exp_rdy = !(q.size() == 3 && !out_ready);
    check("o_ready_def", 64'(rdy0), 64'(exp_rdy));
    check("o_ready_seg", 64'(rdy1), 64'(exp_rdy));
    check("o_ready_rnd", 64'(rdy2), 64'(exp_rdy));
    if (stalled_prev) check("stall_hold", 64'(v0), 64'd1);
    if (q.size() == 0) begin
      check("idle_valid_def", 64'(v0), 64'd0);
      check("idle_valid_seg", 64'(v1), 64'd0);
      check("idle_valid_rnd", 64'(v2), 64'd0);
    end else begin
      if (v0) begin
        check("out_def", sx36(out0), q[0].e0);
        check("user_def", 64'(u0), 64'(q[0].user));
        check("sat_def", 64'(sat0), 64'd0);
      end
      if (v1) begin
        check("out_seg", sx36(out1), q[0].e1);
        check("user_seg", 64'(u1), 64'(q[0].user));
        check("sat_seg", 64'(sat1), 64'd0);
      end
      if (v2) begin
        check("out_rnd", sx16(out2), q[0].e2);
        check("sat_rnd", 64'(sat2), 64'(q[0].s2));
        check("user_rnd", 64'(u2), 64'(q[0].user));
      end
    end
    stalled_prev = v0 && !out_ready;
    if (v0 && out_ready && q.size() > 0) begin
      e = q.pop_front();
      n_res++;
      if (lat_mode) check("latency", 64'(cyc - e.cyc), 64'd3);
    end
    acc_flag = in_valid && rdy0;
    if (acc_flag) begin
      push_model();
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (q.size() > 0 && n < 50) begin
      step();
      n++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic send_one(input logic [17:0] a, input logic [17:0] b, input logic [7:0] u);
    a_in = a;
    b_in = b;
    user_in = u;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("dir_valid", 64'(v0), 64'd1);
  endtask

  initial begin
    int sent;
    int bound;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(v0), 64'd0);
    check("rst_out", 64'(out0), 64'd0);
    check("rst_user", 64'(u0), 64'd0);
    check("rst_sat", 64'(sat2), 64'd0);
    rst_n = 1'b1;

    send_one(18'h20000, 18'h1FFFF, 8'h5A);
    check("dir_def_out", sx36(out0), -64'sd17179738112);
    check("dir_def_user", 64'(u0), 64'h5A);
    check("dir_def_sat", 64'(sat0), 64'd0);
    drain();

    send_one(18'h3FFFB, 18'h3FFFF, 8'h11);
    check("dir_seg_out", sx36(out1), -64'sd1310715);
    check("dir_def_neg1", sx36(out0), 64'sd5);
    drain();

    send_one(18'd100, 18'd7, 8'h22);
    check("dir_rnd_44", sx16(out2), 64'sd44);
    check("dir_rnd_nosat", 64'(sat2), 64'd0);
    drain();

    send_one(18'd20000, 18'd20000, 8'h33);
    check("dir_rnd_clamp", sx16(out2), 64'sd32767);
    check("dir_rnd_sat", 64'(sat2), 64'd1);
    check("dir_def_big", sx36(out0), 64'sd400000000);
    drain();

    send_one(18'h3FF9C, 18'd7, 8'h44);
    check("dir_rnd_neg", sx16(out2), -64'sd44);
    drain();

    // Capacity: three beats fill the pipe, the fourth is refused until a result leaves.
    out_ready = 1'b0;
    in_valid = 1'b1;
    rand_in();
    for (int i = 0; i < 4; i++) begin
      step();
      if (acc_flag) rand_in();
    end
    check("cap_count", 64'(q.size()), 64'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      if (acc_flag) rand_in();
    end
    check("cap_shift", 64'(q.size()), 64'd3);
    drain();

    // Random backpressure and bubbles.
    n_res = 0;
    sent = 0;
    bound = 0;
    rand_in();
    while ((sent < 10 || q.size() > 0) && bound < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid = (sent < 10) && ($urandom_range(0, 3) != 0);
      step();
      if (acc_flag) begin
        sent++;
        rand_in();
      end
      bound++;
    end
    check("bp_sent", 64'(sent), 64'd10);
    check("bp_results", 64'(n_res), 64'd10);
    drain();

    // Full throughput with fixed latency.
    lat_mode = 1'b1;
    n_res = 0;
    n_acc = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      rand_in();
      step();
    end
    drain();
    check("thru_accepted", 64'(n_acc), 64'd100);
    check("thru_results", 64'(n_res), 64'd100);
    lat_mode = 1'b0;

    // Reset with three beats in flight.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_in();
      step();
    end
    check("pre_rst_valid", 64'(v0), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(v0), 64'd0);
    check("mid_rst_out", 64'(out0), 64'd0);
    check("mid_rst_user", 64'(u0), 64'd0);
    check("mid_rst_ready", 64'(rdy0), 64'd1);
    q.delete();
    stalled_prev = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) step();
    lat_mode = 1'b1;
    send_one(18'd1234, 18'h3FF00, 8'h77);
    check("post_rst_out", sx36(out0), -64'sd315904);
    drain();
    lat_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
